// File: rtl/hyperram_target.sv
`timescale 1ns/1ps
// hyperram_target
//   HyperBus responder (device side of a HyperRAM link). CK, CS#, DQ and RWDS
//   from the initiator are oversampled on sys_clk. The block decodes the
//   48-bit command/address and applies a fixed 2x initial latency. It then
//   serves linear or wrapped 16-bit bursts from an internal byte-maskable RAM,
//   or returns constant ID/CR register words.
//
// Ports
//   sys_clk     system clock, at least 4x hb_ck_i
//   sys_rst     asynchronous active-high reset
//   hb_ck_i     HyperBus CK from the initiator
//   hb_cs_n_i   chip select, active-low
//   hb_dq_i     DQ input bus
//   hb_dq_o     DQ output bus (read data)
//   hb_dq_oe    DQ output enable
//   hb_rwds_i   RWDS input (write byte mask, 1 = lane masked)
//   hb_rwds_o   RWDS output (latency indication / read strobe)
//   hb_rwds_oe  RWDS output enable
module hyperram_target #(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 6,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] CR0_VAL = 16'h8F1F
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       hb_ck_i,
  input  logic       hb_cs_n_i,
  input  logic [7:0] hb_dq_i,
  output logic [7:0] hb_dq_o,
  output logic       hb_dq_oe,
  input  logic       hb_rwds_i,
  output logic       hb_rwds_o,
  output logic       hb_rwds_oe
);

  localparam int LAT_CYC = 2 * LATENCY;
  localparam int LW      = $clog2(LAT_CYC + 1);

  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, REGW} state_t;

  state_t state, state_next;

  // two-flop synchronisers
  logic       ck_s1, ck_s2, cs_s1, cs_s2, rwds_s1, rwds_s2;
  logic [7:0] dq_s1, dq_s2;

  logic [39:0]       ca_sr;
  logic [2:0]        byte_cnt;
  logic              is_read, is_reg, is_linear;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       reg_word;
  logic [LW-1:0]     lat_cnt;
  logic [7:0]        hi_byte;
  logic              hi_we, hi_valid;
  logic [7:0]        dq_out;
  logic              rwds_out;

  logic [15:0]       mem [2**ADDR_W];
  logic [15:0]       ram_q;

  logic              rise, fall, ck_edge;
  logic [47:0]       ca_full;
  logic [31:0]       ca_addr;
  logic [ADDR_W-1:0] addr_adv;
  logic [15:0]       rd_word;
  logic              wr_commit;

  assign rise    = ck_s1 & ~ck_s2;
  assign fall    = ~ck_s1 & ck_s2;
  assign ck_edge = rise | fall;

  // the sixth CA byte is decoded straight off the bus on its edge cycle
  assign ca_full = {ca_sr, dq_s2};
  assign ca_addr = {ca_full[44:16], ca_full[2:0]};

  assign addr_adv = is_linear ? ADDR_W'(addr + 1'b1)
                              : {addr[ADDR_W-1:4], 4'(addr[3:0] + 4'd1)};

  assign rd_word = is_reg ? reg_word : ram_q;

  // a word is committed on the falling edge only after its upper byte arrived
  assign wr_commit = (state == WDATA) && fall && hi_valid && !cs_s2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ck_s1   <= 1'b0;
      ck_s2   <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      dq_s1   <= '0;
      dq_s2   <= '0;
      rwds_s1 <= 1'b0;
      rwds_s2 <= 1'b0;
    end else begin
      ck_s1   <= hb_ck_i;
      ck_s2   <= ck_s1;
      cs_s1   <= hb_cs_n_i;
      cs_s2   <= cs_s1;
      dq_s1   <= hb_dq_i;
      dq_s2   <= dq_s1;
      rwds_s1 <= hb_rwds_i;
      rwds_s2 <= rwds_s1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_s2) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  state_next = CA;
        CA:    if (ck_edge && byte_cnt == 3'd5)
                 state_next = (ca_full[47] || !ca_full[46]) ? LAT : REGW;
        LAT:   if (rise && lat_cnt == LW'(LAT_CYC - 1))
                 state_next = is_read ? RDATA : WDATA;
        default: state_next = state;
      endcase
    end
  end

  // outputs decode from state, so they fall together with the return to IDLE
  always_comb begin
    hb_dq_oe   = (state == RDATA);
    hb_dq_o    = (state == RDATA) ? dq_out : 8'h00;
    hb_rwds_oe = (state == CA) || (state == RDATA) ||
                 ((state == LAT) && (is_read || lat_cnt == '0));
    hb_rwds_o  = (state == CA) || ((state == RDATA) && rwds_out);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ca_sr     <= '0;
      byte_cnt  <= '0;
      is_read   <= 1'b0;
      is_reg    <= 1'b0;
      is_linear <= 1'b0;
      addr      <= '0;
      reg_word  <= '0;
      lat_cnt   <= '0;
      hi_byte   <= '0;
      hi_we     <= 1'b0;
      hi_valid  <= 1'b0;
      dq_out    <= '0;
      rwds_out  <= 1'b0;
    end else if (state == IDLE || cs_s2) begin
      // a pending upper byte is dropped when CS# goes away
      byte_cnt <= '0;
      lat_cnt  <= '0;
      hi_valid <= 1'b0;
      dq_out   <= '0;
      rwds_out <= 1'b0;
    end else begin
      case (state)
        CA: if (ck_edge) begin
          ca_sr    <= ca_full[39:0];
          byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt == 3'd5) begin
            is_read   <= ca_full[47];
            is_reg    <= ca_full[46];
            is_linear <= ca_full[45];
            addr      <= ca_addr[ADDR_W-1:0];
            if (ca_addr == 32'h0000_0000)      reg_word <= ID0_VAL;
            else if (ca_addr == 32'h0000_0800) reg_word <= CR0_VAL;
            else                               reg_word <= 16'h0000;
          end
        end
        LAT: if (rise) lat_cnt <= lat_cnt + 1'b1;
        WDATA: begin
          if (rise) begin
            hi_byte  <= dq_s2;
            hi_we    <= ~rwds_s2;
            hi_valid <= 1'b1;
          end else if (wr_commit) begin
            hi_valid <= 1'b0;
            addr     <= addr_adv;
          end
        end
        RDATA: begin
          if (rise) begin
            dq_out   <= rd_word[15:8];
            rwds_out <= 1'b1;
            hi_valid <= 1'b1;
          end else if (fall) begin
            dq_out   <= rd_word[7:0];
            rwds_out <= 1'b0;
            // advancing after the low byte leaves the rest of the half-cycle
            // for the synchronous RAM read of the next word
            if (hi_valid) begin
              hi_valid <= 1'b0;
              addr     <= addr_adv;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // byte-maskable RAM with registered read port
  always_ff @(posedge sys_clk) begin
    if (wr_commit) begin
      if (hi_we)    mem[addr][15:8] <= hi_byte;
      if (!rwds_s2) mem[addr][7:0]  <= dq_s2;
    end
    ram_q <= mem[addr];
  end

endmodule

// File: doc/hyperram_target.md
Name: hyperram_target

Overview:
HyperBus responder: the device end of the HyperRAM link that the SoC's controller drives. It oversamples the initiator's CK, CS# and DQ on sys_clk, decodes the 48-bit command/address, applies fixed 2x latency, and serves linear or wrapped 16-bit bursts from an internal byte-maskable RAM. Used as an FPGA-side HyperRAM stand-in for controller bring-up and board-to-board loopback.

Parameters:
ADDR_W, 10, word-address width; internal RAM holds 2**ADDR_W x 16 bits
LATENCY, 6, initial latency in CK cycles; always doubled (fixed 2x)
ID0_VAL, 16'h0C81, value returned on register read at register address 0
CR0_VAL, 16'h8F1F, value returned on register read at register address 0x800

Ports:
sys_clk  in  1  system clock; frequency must be >= 4x hb_ck_i
sys_rst  in  1  asynchronous active-high reset
hb_ck_i  in  1  HyperBus CK from initiator
hb_cs_n_i  in  1  chip select, active-low
hb_dq_i  in  8  DQ input
hb_dq_o  out  8  DQ output
hb_dq_oe  out  1  DQ output enable
hb_rwds_i  in  1  RWDS input (write byte mask)
hb_rwds_o  out  1  RWDS output
hb_rwds_oe  out  1  RWDS output enable

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Reset is honoured mid-transaction. RAM contents are undefined after reset.
- Input capture: hb_ck_i, hb_cs_n_i, hb_dq_i and hb_rwds_i each pass through identical 2-flop synchronisers.
- Edge detection: rise = s1 & ~s2 on CK; fall = ~s1 & s2. All byte sampling uses the synchronised DQ on the detected edge cycle.
- States:
  - IDLE -> CA when synchronised CS# is low.
  - CA: collect 6 bytes, one per CK edge, MSB byte first. CA[47]=1 is read. CA[46]=1 selects register space. CA[45]=1 is linear burst, 0 is wrapped. Word address = {CA[44:16], CA[2:0]} truncated to ADDR_W.
  - During CA: rwds_oe=1 and rwds_o=1 (signals fixed 2x latency).
  - After byte 6:
    - memory read or write -> LAT.
    - register read -> LAT.
    - register write -> REGW (zero latency).
  - LAT: count 2*LATENCY CK rising edges, then go to RDATA or WDATA. rwds_oe drops at the first rising edge in LAT for writes; it stays 1, rwds_o=0, for reads.
  - WDATA: byte on rising edge -> [15:8]; byte on falling edge -> [7:0]. Byte lane written only if its synchronised RWDS was 0 at capture. Word is committed to RAM on the falling edge, then the address advances.
  - RDATA: 1 sys_clk after a detected rising edge, drive dq_o=word[15:8] and rwds_o=1. 1 sys_clk after a falling edge, drive dq_o=word[7:0] and rwds_o=0. dq_oe=1 throughout RDATA. Next word is prefetched via synchronous RAM read in time for the next rising edge.
  - REGW: consume one word; discard it.
- Register read: address 0 -> ID0_VAL; address 0x800 -> CR0_VAL; any other address -> 16'h0000. The same word repeats for the rest of the burst.
- Address advance:
  - Linear burst: +1 per word, wraps from 2**ADDR_W-1 to 0.
  - Wrapped burst: low 4 bits increment modulo 16; upper bits are held (16-word aligned group).
- CS# deassert (synchronised high) in any state -> IDLE next cycle. dq_oe and rwds_oe drop to 0 the same cycle. A partially captured write word (upper byte only) is discarded.
- CS# low with CK idle: state holds indefinitely; no timeout.

Test Plan:
- Linear write of 4 words 0x1111, 0x2222, 0x3333, 0x4444 at address 0x010, CS# high, then linear read at 0x010 -> returns the same 4 words; rwds_o high on the upper byte of each word.
- Write 0xABCD to address 0x020 with RWDS high on the low byte over an existing 0x5566 -> read returns 0xAB66.
- Register read at address 0 -> 0x0C81 after 12 CK cycles of latency; address 0x800 -> 0x8F1F; address 0x001 -> 0x0000.
- Linear read of 3 words starting at 2**ADDR_W-1 -> addresses 0x3FF, 0x000, 0x001. Wrapped read starting at 0x01E -> 0x01E, 0x01F, 0x010.
- CS# raised after the upper byte of the 2nd write word -> word 1 stored, word 2 unchanged; dq_oe and rwds_oe are 0 within 3 sys_clk.
- sys_rst pulsed mid read burst -> all outputs 0 immediately. The next transaction decodes correctly from CA byte 0.
